// File: rtl/spi_arbiter_if.sv
// Requester-side bus of the SPI arbiter: request/accept handshake plus the
// completion pulse carrying MISO data and an error flag.
interface spi_arbiter_if #(
  parameter int SIZE      = 40,
  parameter int REQ_COUNT = 4,
  parameter int CS_SIZE   = 4
);
  localparam int CSW = $clog2(CS_SIZE);

  logic [REQ_COUNT-1:0]      req_valid_in;
  logic [REQ_COUNT*SIZE-1:0] req_data_in;
  logic [REQ_COUNT*CSW-1:0]  req_cs_in;
  logic [REQ_COUNT-1:0]      req_ready_out;
  logic [REQ_COUNT-1:0]      resp_valid_out;
  logic                      resp_error_out;
  logic [SIZE-1:0]           resp_data_out;

  modport master (
    output req_valid_in, req_data_in, req_cs_in,
    input  req_ready_out, resp_valid_out, resp_error_out, resp_data_out
  );

  modport slave (
    input  req_valid_in, req_data_in, req_cs_in,
    output req_ready_out, resp_valid_out, resp_error_out, resp_data_out
  );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter serialising requester datagrams onto one SPI master,
// with a per-phase timeout and a fixed idle gap between transfers.
module spi_arbiter #(
  parameter int  SIZE       = 40,
  parameter int  REQ_COUNT  = 4,
  parameter int  CS_SIZE    = 4,
  parameter int  GAP_CYCLES = 16,
  parameter int  TIMEOUT    = 4096,
  localparam int CSW        = $clog2(CS_SIZE)
) (
  input  logic             clk_in,
  input  logic             reset_in,
  spi_arbiter_if.slave     bus,
  output logic [SIZE-1:0]  spi_data_out,
  output logic [CSW-1:0]   spi_cs_select_out,
  output logic             spi_send_enable_out,
  input  logic             spi_ready_in,
  input  logic [SIZE-1:0]  spi_data_in
);
  localparam int IW = $clog2(REQ_COUNT);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, START, BUSY, DONE, GAP} state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] owner;
  logic [IW-1:0] pick;
  logic [CW-1:0] cnt;

  // Closest set bit after 'from', wrapping; scanning from farthest to nearest
  // lets the nearest candidate overwrite the rest.
  function automatic logic [IW-1:0] rr_pick(input logic [REQ_COUNT-1:0] v,
                                            input logic [IW-1:0] from);
    logic [IW-1:0] sel;
    int idx;
    sel = from;
    for (int k = REQ_COUNT; k >= 1; k--) begin
      idx = (int'(from) + k) % REQ_COUNT;
      if (v[IW'(idx)]) sel = IW'(idx);
    end
    return sel;
  endfunction

  assign pick = rr_pick(bus.req_valid_in, last);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state               <= IDLE;
      last                <= IW'(REQ_COUNT - 1);
      owner               <= '0;
      cnt                 <= '0;
      spi_data_out        <= '0;
      spi_cs_select_out   <= '0;
      spi_send_enable_out <= 1'b0;
      bus.req_ready_out   <= '0;
      bus.resp_valid_out  <= '0;
      bus.resp_error_out  <= 1'b0;
      bus.resp_data_out   <= '0;
    end else begin
      bus.req_ready_out  <= '0;
      bus.resp_valid_out <= '0;
      bus.resp_error_out <= 1'b0;
      case (state)
        IDLE: begin
          if ((|bus.req_valid_in) && spi_ready_in) begin
            owner               <= pick;
            last                <= pick;
            spi_data_out        <= bus.req_data_in[int'(pick)*SIZE +: SIZE];
            spi_cs_select_out   <= bus.req_cs_in[int'(pick)*CSW +: CSW];
            bus.req_ready_out   <= REQ_COUNT'(1) << pick;
            spi_send_enable_out <= 1'b1;
            cnt                 <= '0;
            state               <= START;
          end
        end
        START: begin
          if (!spi_ready_in) begin
            cnt   <= '0;
            state <= BUSY;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.resp_valid_out  <= REQ_COUNT'(1) << owner;
            bus.resp_error_out  <= 1'b1;
            spi_send_enable_out <= 1'b0;
            cnt                 <= '0;
            state               <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BUSY: begin
          if (spi_ready_in) begin
            bus.resp_data_out   <= spi_data_in;
            bus.resp_valid_out  <= REQ_COUNT'(1) << owner;
            spi_send_enable_out <= 1'b0;
            state               <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.resp_valid_out  <= REQ_COUNT'(1) << owner;
            bus.resp_error_out  <= 1'b1;
            spi_send_enable_out <= 1'b0;
            cnt                 <= '0;
            state               <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= GAP;
        end
        GAP: begin
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// Randomised transaction-level bench for spi_arbiter: a behavioural SPI master
// and requester model predict grant order, timing, responses and timeouts.
module tb_spi_arbiter;
  localparam int SIZE = 40;
  localparam int NREQ = 4;
  localparam int CSS  = 4;
  localparam int CSW  = 2;
  localparam int G    = 16;
  localparam int T    = 64;

  logic            clk = 1'b0;
  logic            reset_in;
  logic [SIZE-1:0] spi_data_out;
  logic [CSW-1:0]  spi_cs_select_out;
  logic            spi_send_enable_out;
  logic            spi_ready;
  logic [SIZE-1:0] spi_miso;

  spi_arbiter_if #(.SIZE(SIZE), .REQ_COUNT(NREQ), .CS_SIZE(CSS)) bus ();

  spi_arbiter #(
    .SIZE(SIZE), .REQ_COUNT(NREQ), .CS_SIZE(CSS), .GAP_CYCLES(G), .TIMEOUT(T)
  ) dut (
    .clk_in              (clk),
    .reset_in            (reset_in),
    .bus                 (bus),
    .spi_data_out        (spi_data_out),
    .spi_cs_select_out   (spi_cs_select_out),
    .spi_send_enable_out (spi_send_enable_out),
    .spi_ready_in        (spi_ready),
    .spi_data_in         (spi_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [NREQ-1:0] pend;
  logic [SIZE-1:0] rdata [NREQ];
  logic [CSW-1:0]  rcs   [NREQ];
  int              model_last;
  int              model_free;
  logic [SIZE-1:0] model_resp;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Next winner: lowest pending index above the last grant, else lowest overall.
  function automatic int rr_model(input logic [NREQ-1:0] v, input int last);
    logic [NREQ-1:0] tmp;
    tmp = v;
    for (int i = last + 1; i < NREQ; i++) if (tmp[i]) return i;
    for (int i = 0; i <= last; i++) if (tmp[i]) return i;
    return 0;
  endfunction

  task automatic drive_reqs();
    bus.req_valid_in = pend;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data_in[i*SIZE +: SIZE] = rdata[i];
      bus.req_cs_in[i*CSW +: CSW]     = rcs[i];
    end
  endtask

  // mode 0: normal, 1: SPI never starts, 2: SPI never finishes, 3: reset mid-BUSY
  task automatic run_xfer(input logic [NREQ-1:0] add, input bit keep, input int mode,
                          input int d1, input int d2, input bit loopback,
                          input logic [NREQ-1:0] late);
    int n, w, g, hi, lo, bad, exp_g;
    logic [SIZE-1:0] ed, miso;
    logic [CSW-1:0]  ec;
    pend = pend | add;
    drive_reqs();
    w     = rr_model(pend, model_last);
    ed    = rdata[w];
    ec    = rcs[w];
    exp_g = (cyc + 1 > model_free) ? cyc + 1 : model_free;
    n = 0; hi = 0;
    while (bus.req_ready_out == '0 && n < 400) begin
      if (spi_send_enable_out) hi++;
      @(negedge clk); n++;
    end
    check_eq("grant_seen", 64'(n < 400), 1);
    check_eq("grant_cycle", 64'(cyc), 64'(exp_g));
    check_eq("gap_enable_low", 64'(hi), 0);
    check_eq("grant_onehot", 64'(bus.req_ready_out), 64'(1) << w);
    check_eq("spi_data", 64'(spi_data_out), 64'(ed));
    check_eq("spi_cs", 64'(spi_cs_select_out), 64'(ec));
    check_eq("enable_on_grant", 64'(spi_send_enable_out), 1);
    model_last = w;
    g = cyc;
    if (!keep) begin
      pend[w] = 1'b0;
      drive_reqs();
    end
    @(negedge clk);
    check_eq("ready_pulse_width", 64'(bus.req_ready_out), 0);
    lo = 0;
    if (mode != 1) begin
      repeat (d1 - 1) begin
        if (!spi_send_enable_out) lo++;
        @(negedge clk);
      end
      spi_ready = 1'b0;
    end
    if (late != '0) begin
      pend = pend | late;
      drive_reqs();
    end
    case (mode)
      0: begin
        repeat (d2) begin
          if (!spi_send_enable_out) lo++;
          @(negedge clk);
        end
        miso      = loopback ? spi_data_out : {$urandom, $urandom};
        spi_miso  = miso;
        spi_ready = 1'b1;
        @(negedge clk);
        check_eq("enable_held", 64'(lo), 0);
        check_eq("resp_valid", 64'(bus.resp_valid_out), 64'(1) << w);
        check_eq("resp_error", 64'(bus.resp_error_out), 0);
        check_eq("resp_data", 64'(bus.resp_data_out), 64'(miso));
        check_eq("enable_done", 64'(spi_send_enable_out), 0);
        check_eq("spi_data_stable", 64'(spi_data_out), 64'(ed));
        model_resp = miso;
        model_free = cyc + G + 2;
        @(negedge clk);
        check_eq("resp_pulse_width", 64'(bus.resp_valid_out), 0);
      end
      1, 2: begin
        n = 0;
        while (bus.resp_valid_out == '0 && n < T + 50) begin
          if (!spi_send_enable_out) lo++;
          @(negedge clk); n++;
        end
        check_eq("to_enable_held", 64'(lo), 0);
        check_eq("to_cycle", 64'(cyc), (mode == 1) ? 64'(g + T) : 64'(g + d1 + 1 + T));
        check_eq("to_resp_valid", 64'(bus.resp_valid_out), 64'(1) << w);
        check_eq("to_resp_error", 64'(bus.resp_error_out), 1);
        check_eq("to_enable_low", 64'(spi_send_enable_out), 0);
        check_eq("to_resp_data_kept", 64'(bus.resp_data_out), 64'(model_resp));
        spi_ready  = 1'b1;
        model_free = cyc + G + 1;
        @(negedge clk);
        check_eq("to_pulse_width", 64'(bus.resp_valid_out), 0);
      end
      default: begin
        repeat (2) @(negedge clk);
        reset_in = 1'b1;
        #1;
        check_eq("rst_enable_drop", 64'(spi_send_enable_out), 0);
        check_eq("rst_spi_data", 64'(spi_data_out), 0);
        spi_ready = 1'b1;
        bad = 0;
        repeat (3) begin
          @(negedge clk);
          if (bus.resp_valid_out != '0) bad++;
        end
        check_eq("rst_no_resp", 64'(bad), 0);
        reset_in   = 1'b0;
        model_last = NREQ - 1;
        model_free = cyc + 1;
        model_resp = '0;
      end
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] add, late;
    int mode;
    reset_in  = 1'b1;
    spi_ready = 1'b1;
    spi_miso  = '0;
    pend      = '0;
    for (int i = 0; i < NREQ; i++) begin
      rdata[i] = {$urandom, $urandom};
      rcs[i]   = CSW'($urandom);
    end
    drive_reqs();
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 64'(bus.req_ready_out), 0);
    check_eq("rst_resp_valid", 64'(bus.resp_valid_out), 0);
    check_eq("rst_resp_error", 64'(bus.resp_error_out), 0);
    check_eq("rst_resp_data", 64'(bus.resp_data_out), 0);
    check_eq("rst_spi_data0", 64'(spi_data_out), 0);
    check_eq("rst_spi_cs", 64'(spi_cs_select_out), 0);
    check_eq("rst_enable", 64'(spi_send_enable_out), 0);
    reset_in   = 1'b0;
    model_last = NREQ - 1;
    model_free = cyc + 1;
    model_resp = '0;

    // single request with loopback MISO
    rdata[0] = 40'h12_3456_789A;
    rcs[0]   = 2'd2;
    run_xfer(4'b0001, 1'b0, 0, 2, 3, 1'b1, 4'b0000);
    // late request from 2 while 0 is in BUSY
    run_xfer(4'b0001, 1'b0, 0, 1, 4, 1'b0, 4'b0100);
    run_xfer(4'b0000, 1'b0, 0, 2, 2, 1'b0, 4'b0000);
    // reset in the middle of BUSY
    run_xfer(4'b0001, 1'b0, 3, 2, 0, 1'b0, 4'b0000);
    // held contention after reset: 0,1,2,3,0
    for (int k = 0; k < 5; k++) run_xfer(4'b1111, 1'b1, 0, 1, 2, 1'b0, 4'b0000);
    // wrap-around from last grant 3
    pend = 4'b1000;
    run_xfer(4'b0000, 1'b0, 0, 1, 1, 1'b0, 4'b0000);
    pend = 4'b1010;
    run_xfer(4'b0000, 1'b0, 0, 1, 1, 1'b0, 4'b0000);
    run_xfer(4'b0000, 1'b0, 0, 1, 1, 1'b0, 4'b0000);
    // timeouts in both handshake phases
    run_xfer(4'b0100, 1'b0, 1, 1, 0, 1'b0, 4'b0000);
    run_xfer(4'b0010, 1'b0, 2, 3, 0, 1'b0, 4'b0000);

    for (int it = 0; it < 30; it++) begin
      add = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          rdata[i] = {$urandom, $urandom};
          rcs[i]   = CSW'($urandom);
        end
      end
      if ((pend | add) == '0) add = NREQ'(1) << $urandom_range(0, NREQ - 1);
      mode = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      late = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
      run_xfer(add, 1'($urandom_range(0, 1)), mode, $urandom_range(1, 5),
               $urandom_range(1, 6), 1'($urandom_range(0, 1)), late);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
